// File: rtl/charlie7x5_scan.sv
// Charlieplexed 7-pin / 35-LED scanner with a Wishbone register interface.
// A back buffer is written over the bus and copied into the front buffer at
// frame boundaries. The scan blanks all pins before every phase, which
// prevents ghosting between phases.
module charlie7x5_scan #(
    parameter int TICKS_PER_PHASE = 4800,
    parameter int BLANK_TICKS     = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [2:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic [6:0] charlie7x5_oe,
    output logic [6:0] charlie7x5_o
);

    localparam int MAX_TICKS = (TICKS_PER_PHASE > BLANK_TICKS) ? TICKS_PER_PHASE : BLANK_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(TICKS_PER_PHASE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [2:0]       CTRL_ADR   = 3'd7;

    typedef enum logic [1:0] {
        ST_DISABLED,
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              enable_q, enable_d;
    logic              swap_pending_q, swap_pending_d;
    logic [6:0][4:0]   back_q, back_d;
    logic [6:0][4:0]   front_q, front_d;
    logic              ack_q;
    logic [7:0]        dat_q, dat_d;
    logic [6:0]        oe_q, oe_d;
    logic [6:0]        o_q, o_d;

    logic              bus_req;
    logic              wr_ctrl;
    logic              do_swap;
    logic [7:0]        rd_data;
    int                pin_sum;
    logic [2:0]        pin;

    // Data bits above the 5-bit entry width have no destination.
    logic unused_dat;
    assign unused_dat = &{1'b0, wb_dat_i[7:5]};

    // Bus decode: one request per ack, so a held strobe is served every other cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        bus_req = wb_cyc_i & wb_stb_i & ~ack_q;
        wr_ctrl = bus_req & wb_we_i & (wb_adr_i == CTRL_ADR);
        rd_data = {6'b0, swap_pending_q, enable_q};
        back_d  = back_q;
        for (int i = 0; i < 7; i++) begin
            if (wb_adr_i == 3'(i)) begin
                rd_data = {3'b0, back_q[3'(i)]};
                if (bus_req && wb_we_i) begin
                    back_d[3'(i)] = wb_dat_i[4:0];
                end
            end
        end
        dat_d    = bus_req ? rd_data : dat_q;
        enable_d = wr_ctrl ? wb_dat_i[0] : enable_q;
    end

    // Scan sequencer: next state, phase, tick counter and buffer swap decision.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        do_swap = 1'b0;
        if (!enable_q) begin
            // Disable is immediate from any state; a pending swap is only taken once idle.
            state_d = ST_DISABLED;
            phase_d = 3'd0;
            cnt_d   = '0;
            do_swap = (state_q == ST_DISABLED) && swap_pending_q;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    state_d = ST_BLANK;
                    phase_d = 3'd0;
                    cnt_d   = '0;
                    do_swap = swap_pending_q;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (phase_q == 3'd6) begin
                            phase_d = 3'd0;
                            do_swap = swap_pending_q;
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_DISABLED;
                    phase_d = 3'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        front_d = do_swap ? back_q : front_q;

        // A CTRL write requesting a swap wins over the swap that clears the flag.
        swap_pending_d = swap_pending_q;
        if (do_swap) begin
            swap_pending_d = 1'b0;
        end
        if (wr_ctrl && wb_dat_i[1]) begin
            swap_pending_d = 1'b1;
        end
    end

    // Pin drive computed from the next state so the registered pins line up with the state register.
    always_comb begin
        oe_d    = 7'b0;
        o_d     = 7'b0;
        pin_sum = 0;
        pin     = 3'd0;
        if (state_d == ST_DRIVE) begin
            oe_d[phase_d] = 1'b1;
            o_d[phase_d]  = 1'b1;
            for (int k = 0; k < 5; k++) begin
                pin_sum = int'(phase_d) + 1 + k;
                if (pin_sum >= 7) begin
                    pin_sum = pin_sum - 7;
                end
                pin = 3'(pin_sum);
                if (front_d[phase_d][3'(k)]) begin
                    oe_d[pin] = 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_DISABLED;
            phase_q        <= 3'd0;
            cnt_q          <= '0;
            enable_q       <= 1'b0;
            swap_pending_q <= 1'b0;
            // NOTE: the LED buffers are reset because a frame must never show stale power-up content.
            back_q         <= '0;
            front_q        <= '0;
            ack_q          <= 1'b0;
            dat_q          <= 8'h00;
            oe_q           <= 7'b0;
            o_q            <= 7'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            enable_q       <= enable_d;
            swap_pending_q <= swap_pending_d;
            back_q         <= back_d;
            front_q        <= front_d;
            ack_q          <= bus_req;
            dat_q          <= dat_d;
            oe_q           <= oe_d;
            o_q            <= o_d;
        end
    end

    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = dat_q;
    assign charlie7x5_oe = oe_q;
    assign charlie7x5_o  = o_q;

endmodule

// File: tb/tb_charlie7x5_scan.sv
// Directed bench for charlie7x5_scan with TICKS_PER_PHASE=4, BLANK_TICKS=2.
// Read data is checked against a scoreboard queue filled when each read is issued.
module tb_charlie7x5_scan;

    logic       clk;
    logic       rst_n;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [2:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic [6:0] charlie7x5_oe;
    logic [6:0] charlie7x5_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    charlie7x5_scan #(
        .TICKS_PER_PHASE(4),
        .BLANK_TICKS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .charlie7x5_oe(charlie7x5_oe),
        .charlie7x5_o(charlie7x5_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; read data is popped from the scoreboard on ack.
    task automatic bus(input logic we, input logic [2:0] adr, input logic [7:0] dat, input string tag);
        int n;
        logic [7:0] exp;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wb_ack_o && n < 8);
        check({tag, "_ack"}, 16'(wb_ack_o), 16'd1);
        if (!we && wb_ack_o && sb.size() > 0) begin
            exp = sb.pop_front();
            check(tag, 16'(wb_dat_o), 16'(exp));
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] adr, input logic [7:0] exp, input string tag);
        sb.push_back(exp);
        bus(1'b0, adr, 8'h00, tag);
    endtask

    task automatic expect_pins(input logic [6:0] eoe, input logic [6:0] eo, input string tag);
        tick();
        check(tag, {2'b0, charlie7x5_oe, charlie7x5_o}, {2'b0, eoe, eo});
    endtask

    task automatic wait_pins(input logic [6:0] eoe, input logic [6:0] eo, input int limit, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(charlie7x5_oe === eoe && charlie7x5_o === eo) && n < limit);
        check(tag, {2'b0, charlie7x5_oe, charlie7x5_o}, {2'b0, eoe, eo});
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = 3'd0;
        wb_dat_i = 8'h00;

        // Reset values.
        repeat (3) tick();
        check("rst_ack", 16'(wb_ack_o), 16'd0);
        check("rst_dat", 16'(wb_dat_o), 16'd0);
        check("rst_oe", 16'(charlie7x5_oe), 16'd0);
        check("rst_o", 16'(charlie7x5_o), 16'd0);
        rst_n = 1'b1;

        // Idle: all outputs off for 20 cycles, CTRL reads zero.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_out", {1'b0, wb_ack_o, charlie7x5_oe, charlie7x5_o}, 16'd0);
        end
        read_reg(3'd7, 8'h00, "idle_ctrl");

        // First frame: back[0]=0x01, enable with swap.
        bus(1'b1, 3'd0, 8'h01, "wr_back0");
        read_reg(3'd0, 8'h01, "rd_back0");
        bus(1'b1, 3'd7, 8'h03, "wr_ctrl_en");
        for (int i = 0; i < 2; i++) expect_pins(7'b0, 7'b0, "blank0");
        for (int i = 0; i < 4; i++) expect_pins(7'b0000011, 7'b0000001, "drive0");
        for (int i = 0; i < 2; i++) expect_pins(7'b0, 7'b0, "blank1");
        expect_pins(7'b0000010, 7'b0000010, "drive1");
        read_reg(3'd7, 8'h01, "ctrl_after_swap");

        // back[6]=0x1F with swap: pins 0..4 sink while pin 6 sources.
        wait_pins(7'b0000011, 7'b0000001, 100, "sync_drive0");
        bus(1'b1, 3'd6, 8'h1F, "wr_back6");
        bus(1'b1, 3'd7, 8'h03, "wr_ctrl_swap6");
        read_reg(3'd7, 8'h03, "ctrl_pending6");
        wait_pins(7'b1011111, 7'b1000000, 150, "drive6_full");
        read_reg(3'd7, 8'h01, "ctrl_swapped6");

        // back[2]=0x1F without swap: front stays unchanged for three frames.
        bus(1'b1, 3'd2, 8'hFF, "wr_back2");
        read_reg(3'd2, 8'h1F, "rd_back2_masked");
        for (int f = 0; f < 3; f++) begin
            wait_pins(7'b0000100, 7'b0000100, 100, "drive2_old");
            wait_pins(7'b0, 7'b0, 10, "blank3");
        end
        bus(1'b1, 3'd7, 8'h03, "wr_ctrl_swap2");
        read_reg(3'd7, 8'h03, "ctrl_pending2");
        wait_pins(7'b0000011, 7'b0000001, 100, "drive0_after_wrap");
        read_reg(3'd7, 8'h01, "ctrl_swapped2");
        wait_pins(7'b1111101, 7'b0000100, 100, "drive2_new");

        // Disable during DRIVE(3), then re-enable from BLANK(0).
        wait_pins(7'b0001000, 7'b0001000, 100, "sync_drive3");
        bus(1'b1, 3'd7, 8'h00, "wr_ctrl_dis");
        for (int i = 0; i < 5; i++) expect_pins(7'b0, 7'b0, "disabled_off");
        read_reg(3'd7, 8'h00, "ctrl_dis");
        bus(1'b1, 3'd7, 8'h01, "wr_ctrl_reen");
        for (int i = 0; i < 2; i++) expect_pins(7'b0, 7'b0, "reen_blank0");
        expect_pins(7'b0000011, 7'b0000001, "reen_drive0");

        // Held strobe reading CTRL: ack on alternate cycles.
        tick();
        repeat (3) sb.push_back(8'h01);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 3'd7;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("held_ack", 16'(wb_ack_o), (i % 2 == 0) ? 16'd1 : 16'd0);
            if (wb_ack_o && sb.size() > 0) begin
                check("held_dat", 16'(wb_dat_o), 16'(sb.pop_front()));
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        check("sb_empty", 16'(sb.size()), 16'd0);

        // Reset during a write: no ack, write discarded, everything cleared.
        tick();
        tick();
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 3'd1;
        wb_dat_i = 8'h1F;
        rst_n    = 1'b0;
        tick();
        check("rst_mid_ack", 16'(wb_ack_o), 16'd0);
        check("rst_mid_pins", {2'b0, charlie7x5_oe, charlie7x5_o}, 16'd0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("rst_mid_ack2", 16'(wb_ack_o), 16'd0);
        read_reg(3'd1, 8'h00, "rst_back1");
        read_reg(3'd6, 8'h00, "rst_back6");
        read_reg(3'd7, 8'h00, "rst_ctrl");
        for (int i = 0; i < 4; i++) expect_pins(7'b0, 7'b0, "rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
